// File: rtl/jesd204_scr_seq_pkg.sv
// Shared encodings for the JESD204 TX lane sequencer: link states, K-characters, datapath width.
`default_nettype none

package jesd204_scr_seq_pkg;

   localparam int DATA_PATH_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CGS  = 2'd1,
      ILAS = 2'd2,
      DATA = 2'd3
   } link_state_e;

   localparam logic [7:0] K28_5 = 8'hBC;
   localparam logic [7:0] K28_0 = 8'h1C;
   localparam logic [7:0] K28_3 = 8'h7C;
   localparam logic [7:0] K28_4 = 8'h9C;

endpackage

`default_nettype wire

// File: rtl/jesd204_scr_seq_ilas_gen.sv
// ILAS word generator: octet ramp with multiframe start/end/config K-character overlays.
`default_nettype none

module jesd204_scr_seq_ilas_gen
   import jesd204_scr_seq_pkg::*;
(
   input  logic [7:0]  beat_cnt_i,
   input  logic [3:0]  mf_cnt_i,
   input  logic        last_beat_i,
   output logic [31:0] ilas_data_o,
   output logic [3:0]  ilas_charisk_o
);

   logic [7:0] base;

   always_comb begin
      base           = beat_cnt_i << 2;
      ilas_data_o    = {base + 8'd3, base + 8'd2, base + 8'd1, base};
      ilas_charisk_o = '0;
      if (beat_cnt_i == 8'd0) begin
         ilas_data_o[7:0]  = K28_0;
         ilas_charisk_o[0] = 1'b1;
         // The second multiframe announces the link configuration.
         if (mf_cnt_i == 4'd1) begin
            ilas_data_o[15:8] = K28_4;
            ilas_charisk_o[1] = 1'b1;
         end
      end
      if (last_beat_i) begin
         ilas_data_o[31:24] = K28_3;
         ilas_charisk_o[3]  = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/jesd204_scrambler_seq.sv
// JESD204 TX lane sequencer (IDLE/CGS/ILAS/DATA) driving one scrambler and the PHY word.
// Define JESD204_SCR_SEQ_SYNC_DEBOUNCE_EN to require 4 consecutive low SYNC~ cycles before DATA->CGS.
`default_nettype none

module jesd204_scrambler_seq #(
   parameter int DATA_PATH_WIDTH  = 4,
   parameter int ILAS_MULTIFRAMES = 4
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic [7:0]                     cfg_beats_per_multiframe,
   input  logic                           cfg_scrambler_disable,
   input  logic                           link_enable,
   input  logic                           sync_n,
   input  logic                           lmfc_edge,
   input  logic [DATA_PATH_WIDTH*8-1:0]   tx_data,
   output logic                           tx_ready,
   output logic                           scr_reset,
   output logic                           scr_enable,
   output logic [DATA_PATH_WIDTH*8-1:0]   scr_data_in,
   input  logic [DATA_PATH_WIDTH*8-1:0]   scr_data_out,
   output logic [DATA_PATH_WIDTH*8-1:0]   phy_data,
   output logic [DATA_PATH_WIDTH-1:0]     phy_charisk,
   output logic [1:0]                     link_state
);

   import jesd204_scr_seq_pkg::*;

   link_state_e                  state_q, state_d;
   logic [7:0]                   beat_cnt_q, beat_cnt_d;
   logic [3:0]                   mf_cnt_q, mf_cnt_d;
   logic [DATA_PATH_WIDTH*8-1:0] phy_data_q, phy_data_d;
   logic [DATA_PATH_WIDTH-1:0]   phy_charisk_q, phy_charisk_d;
   logic                         last_beat;
   logic                         resync_req;
   logic [31:0]                  ilas_data;
   logic [3:0]                   ilas_charisk;

   assign last_beat   = (beat_cnt_q == cfg_beats_per_multiframe);
   assign tx_ready    = (state_q == DATA);
   assign scr_reset   = (state_q != DATA);
   assign scr_enable  = (state_q == DATA) && !cfg_scrambler_disable;
   assign scr_data_in = tx_data;
   assign phy_data    = phy_data_q;
   assign phy_charisk = phy_charisk_q;
   assign link_state  = state_q;

   jesd204_scr_seq_ilas_gen u_ilas_gen (
      .beat_cnt_i     (beat_cnt_q),
      .mf_cnt_i       (mf_cnt_q),
      .last_beat_i    (last_beat),
      .ilas_data_o    (ilas_data),
      .ilas_charisk_o (ilas_charisk)
   );

`ifdef JESD204_SCR_SEQ_SYNC_DEBOUNCE_EN
   logic [1:0] deb_cnt_q, deb_cnt_d;

   always_comb begin
      deb_cnt_d = '0;
      if ((state_q == DATA) && !sync_n && (deb_cnt_q != 2'd3)) begin
         deb_cnt_d = deb_cnt_q + 2'd1;
      end
   end

   assign resync_req = !sync_n && (deb_cnt_q == 2'd3);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         deb_cnt_q <= '0;
      end else begin
         deb_cnt_q <= deb_cnt_d;
      end
   end
`else
   assign resync_req = !sync_n;
`endif

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      mf_cnt_d      = mf_cnt_q;
      phy_data_d    = '0;
      phy_charisk_d = '0;
      case (state_q)
         IDLE: begin
            if (link_enable) state_d = CGS;
         end
         CGS: begin
            phy_data_d    = {DATA_PATH_WIDTH{K28_5}};
            phy_charisk_d = '1;
            if (sync_n && lmfc_edge) begin
               state_d    = ILAS;
               beat_cnt_d = '0;
               mf_cnt_d   = '0;
            end
         end
         ILAS: begin
            phy_data_d    = ilas_data;
            phy_charisk_d = ilas_charisk;
            if (!sync_n) begin
               state_d = CGS;
            end else if (last_beat) begin
               beat_cnt_d = '0;
               mf_cnt_d   = mf_cnt_q + 4'd1;
               if (mf_cnt_q == 4'(ILAS_MULTIFRAMES - 1)) state_d = DATA;
            end else begin
               beat_cnt_d = beat_cnt_q + 8'd1;
            end
         end
         DATA: begin
            phy_data_d = scr_enable ? scr_data_out : tx_data;
            if (resync_req) state_d = CGS;
         end
         default: state_d = IDLE;
      endcase
      // Disabling the link wins over every other transition.
      if (!link_enable) state_d = IDLE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= IDLE;
         beat_cnt_q    <= '0;
         mf_cnt_q      <= '0;
         phy_data_q    <= '0;
         phy_charisk_q <= '0;
      end else begin
         state_q       <= state_d;
         beat_cnt_q    <= beat_cnt_d;
         mf_cnt_q      <= mf_cnt_d;
         phy_data_q    <= phy_data_d;
         phy_charisk_q <= phy_charisk_d;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_jesd204_scrambler_seq.sv
// Self-checking bench for jesd204_scrambler_seq with a behavioural 1+x^14+x^15 scrambler/descrambler.
`default_nettype none
`timescale 1ns/1ps

module tb_jesd204_scrambler_seq;

   localparam int         MF   = 4;
   localparam logic [14:0] SEED = 15'h7f80;

   logic        clk = 1'b0;
   logic        resetn;
   logic [7:0]  cfg_beats_per_multiframe;
   logic        cfg_scrambler_disable;
   logic        link_enable;
   logic        sync_n;
   logic        lmfc_edge;
   logic [31:0] tx_data;
   logic        tx_ready;
   logic        scr_reset;
   logic        scr_enable;
   logic [31:0] scr_data_in;
   logic [31:0] scr_data_out;
   logic [31:0] phy_data;
   logic [3:0]  phy_charisk;
   logic [1:0]  link_state;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   jesd204_scrambler_seq #(
      .DATA_PATH_WIDTH  (4),
      .ILAS_MULTIFRAMES (MF)
   ) dut (
      .clk                      (clk),
      .resetn                   (resetn),
      .cfg_beats_per_multiframe (cfg_beats_per_multiframe),
      .cfg_scrambler_disable    (cfg_scrambler_disable),
      .link_enable              (link_enable),
      .sync_n                   (sync_n),
      .lmfc_edge                (lmfc_edge),
      .tx_data                  (tx_data),
      .tx_ready                 (tx_ready),
      .scr_reset                (scr_reset),
      .scr_enable               (scr_enable),
      .scr_data_in              (scr_data_in),
      .scr_data_out             (scr_data_out),
      .phy_data                 (phy_data),
      .phy_charisk              (phy_charisk),
      .link_state               (link_state)
   );

   // Serial self-synchronising scrambler, MSB first; result is {next_state, word}.
   function automatic logic [46:0] scramble(input logic [31:0] d, input logic [14:0] s);
      logic [14:0] st;
      logic [31:0] o;
      st = s;
      for (int i = 31; i >= 0; i--) begin
         o[i] = d[i] ^ st[14] ^ st[13];
         st   = {st[13:0], o[i]};
      end
      return {st, o};
   endfunction

   function automatic logic [46:0] descramble(input logic [31:0] d, input logic [14:0] s);
      logic [14:0] st;
      logic [31:0] o;
      st = s;
      for (int i = 31; i >= 0; i--) begin
         o[i] = d[i] ^ st[14] ^ st[13];
         st   = {st[13:0], d[i]};
      end
      return {st, o};
   endfunction

   logic [14:0] scr_q;
   logic [46:0] scr_res;
   assign scr_res      = scramble(scr_data_in, scr_q);
   assign scr_data_out = scr_res[31:0];

   always @(posedge clk) begin
      if (scr_reset)       scr_q <= SEED;
      else if (scr_enable) scr_q <= scr_res[46:32];
   end

   // Expected ILAS word for absolute ILAS beat k with (bpm+1) beats per multiframe.
   function automatic void ilas_ref(input int k, input int bpm,
                                    output logic [31:0] w, output logic [3:0] kf);
      int         beat;
      int         mf;
      logic [7:0] oct [4];
      beat = k % (bpm + 1);
      mf   = k / (bpm + 1);
      for (int o = 0; o < 4; o++) oct[o] = 8'((beat * 4 + o) % 256);
      kf = '0;
      if (beat == 0) begin
         oct[0] = 8'h1C; kf[0] = 1'b1;
         if (mf == 1) begin oct[1] = 8'h9C; kf[1] = 1'b1; end
      end
      if (beat == bpm) begin oct[3] = 8'h7C; kf[3] = 1'b1; end
      w = {oct[3], oct[2], oct[1], oct[0]};
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Assumes the link is already in CGS; ends with sync_n high and no LMFC edge.
   task automatic do_cgs(input int n);
      for (int i = 0; i < n; i++) begin
         sync_n    = 1'b0;
         lmfc_edge = 1'($urandom_range(0, 1));
         tick();
         check_eq("cgs_state", 32'(link_state), 32'd1);
         check_eq("cgs_data", phy_data, 32'hBCBCBCBC);
         check_eq("cgs_k", 32'(phy_charisk), 32'hF);
      end
      sync_n    = 1'b1;
      lmfc_edge = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("cgs_hold", 32'(link_state), 32'd1);
      end
   endtask

   // mode 0: full ILAS into DATA; 1: sync_n drop at beat abort_at; 2: async reset at beat abort_at.
   task automatic do_ilas(input int bpm, input int abort_at, input int mode);
      logic [31:0] w;
      logic [3:0]  kf;
      int          n;
      n = MF * (bpm + 1);
      cfg_beats_per_multiframe = 8'(bpm);
      lmfc_edge = 1'b1;
      tick();
      lmfc_edge = 1'b0;
      check_eq("ilas_enter", 32'(link_state), 32'd2);
      check_eq("ilas_cgs_tail", phy_data, 32'hBCBCBCBC);
      for (int k = 0; k < n; k++) begin
         ilas_ref(k, bpm, w, kf);
         if (mode == 1 && k == abort_at) begin
            sync_n = 1'b0;
            tick();
            check_eq("ilas_drop_state", 32'(link_state), 32'd1);
            check_eq("ilas_drop_data", phy_data, w);
            return;
         end
         if (mode == 2 && k == abort_at) begin
            #2 resetn = 1'b0;
            #1;
            check_eq("arst_state", 32'(link_state), 32'd0);
            check_eq("arst_data", phy_data, 32'd0);
            check_eq("arst_k", 32'(phy_charisk), 32'd0);
            check_eq("arst_scr_reset", 32'(scr_reset), 32'd1);
            check_eq("arst_ready", 32'(tx_ready), 32'd0);
            tick();
            check_eq("arst_hold", 32'(link_state), 32'd0);
            resetn = 1'b1;
            return;
         end
         tick();
         check_eq($sformatf("ilas_data_b%0d", k), phy_data, w);
         check_eq($sformatf("ilas_k_b%0d", k), 32'(phy_charisk), 32'(kf));
         check_eq("ilas_state", 32'(link_state), (k == n - 1) ? 32'd3 : 32'd2);
      end
   endtask

   task automatic do_data(input int n, input bit dis, input bit ramp);
      logic [14:0] ds;
      logic [31:0] d;
      logic [46:0] r;
      ds = SEED;
      cfg_scrambler_disable = dis;
      for (int j = 0; j < n; j++) begin
         d = ramp ? (32'h03020100 + 32'h04040404 * 32'(j)) : 32'($urandom);
         tx_data = d;
         #1;
         check_eq("data_ready", 32'(tx_ready), 32'd1);
         check_eq("data_scr_reset", 32'(scr_reset), 32'd0);
         check_eq("data_scr_en", 32'(scr_enable), 32'(!dis));
         check_eq("data_scr_in", scr_data_in, d);
         tick();
         check_eq("data_k", 32'(phy_charisk), 32'd0);
         check_eq("data_state", 32'(link_state), 32'd3);
         if (dis) begin
            check_eq("data_raw", phy_data, d);
         end else begin
            r  = descramble(phy_data, ds);
            ds = r[46:32];
            check_eq("data_descr", r[31:0], d);
         end
      end
   endtask

   task automatic do_resync();
`ifdef JESD204_SCR_SEQ_SYNC_DEBOUNCE_EN
      sync_n = 1'b0;
      tick();
      sync_n = 1'b1;
      check_eq("deb_1cyc_stay", 32'(link_state), 32'd3);
      for (int i = 0; i < 3; i++) begin sync_n = 1'b0; tick(); end
      sync_n = 1'b1;
      check_eq("deb_3cyc_stay", 32'(link_state), 32'd3);
      tick();
      check_eq("deb_after_3", 32'(link_state), 32'd3);
      for (int i = 0; i < 3; i++) begin sync_n = 1'b0; tick(); end
      check_eq("deb_3of4_stay", 32'(link_state), 32'd3);
      tick();
`else
      sync_n = 1'b0;
      tick();
`endif
      check_eq("resync_state", 32'(link_state), 32'd1);
      check_eq("resync_ready", 32'(tx_ready), 32'd0);
      check_eq("resync_scr_reset", 32'(scr_reset), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetn                   = 1'b0;
      cfg_beats_per_multiframe = 8'd3;
      cfg_scrambler_disable    = 1'b0;
      link_enable              = 1'b0;
      sync_n                   = 1'b0;
      lmfc_edge                = 1'b0;
      tx_data                  = 32'($urandom);
      #3;
      check_eq("rst_data", phy_data, 32'd0);
      check_eq("rst_k", 32'(phy_charisk), 32'd0);
      check_eq("rst_state", 32'(link_state), 32'd0);
      check_eq("rst_ready", 32'(tx_ready), 32'd0);
      check_eq("rst_scr_reset", 32'(scr_reset), 32'd1);
      check_eq("rst_scr_en", 32'(scr_enable), 32'd0);
      check_eq("rst_scr_in", scr_data_in, tx_data);
      tick();
      resetn = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check_eq("idle_data", phy_data, 32'd0);
         check_eq("idle_state", 32'(link_state), 32'd0);
         check_eq("idle_scr_reset", 32'(scr_reset), 32'd1);
      end

      link_enable = 1'b1;
      tick();
      check_eq("enable_cgs", 32'(link_state), 32'd1);
      do_cgs(20);
      do_ilas(3, -1, 0);
      do_data(8, 1'b0, 1'b1);
      do_resync();

      do_cgs(5);
      do_ilas(0, -1, 0);
      do_data(8, 1'b1, 1'b0);
      do_resync();

      do_cgs(4);
      begin
         int b;
         b = $urandom_range(1, 9);
         do_ilas(b, $urandom_range(0, MF * (b + 1) - 1), 1);
      end

      do_cgs(3);
      do_ilas(70, -1, 0);
      do_data(16, 1'b0, 1'b0);

      link_enable = 1'b0;
      tick();
      check_eq("disable_state", 32'(link_state), 32'd0);
      check_eq("disable_ready", 32'(tx_ready), 32'd0);
      tick();
      check_eq("disable_data", phy_data, 32'd0);
      check_eq("disable_k", 32'(phy_charisk), 32'd0);

      link_enable = 1'b1;
      tick();
      check_eq("reenable_cgs", 32'(link_state), 32'd1);
      do_cgs(3);
      do_ilas(2, 5, 2);
      tick();
      check_eq("post_arst_cgs", 32'(link_state), 32'd1);
      check_eq("post_arst_data", phy_data, 32'd0);
      do_cgs(3);
      do_ilas(1, -1, 0);
      do_data(6, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
